// File: rtl/mem_access_stage_pkg.sv
// Shared constants and types for the MEM stage: FSM encoding and the
// byte address that maps to data-memory word 0.
package mem_access_stage_pkg;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  localparam int unsigned MEM_BASE_DEFAULT = 1024;

endpackage

// File: rtl/mem_access_stage_wb_reg.sv
// MEM/WB pipeline register feeding the register-file write port.
// wb_en is refreshed every cycle; dest/value only load when ld_en_i is set.
module mem_wb_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_en_i,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_dest_i,
  input  logic [DATA_W-1:0]     wb_value_i,
  output logic                  wb_en_o,
  output logic [REG_ADDR_W-1:0] wb_dest_o,
  output logic [DATA_W-1:0]     wb_value_o
);

  logic                  wb_en_q;
  logic [REG_ADDR_W-1:0] wb_dest_q;
  logic [DATA_W-1:0]     wb_value_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_value_q <= '0;
    end else begin
      wb_en_q <= wb_en_i;
      if (ld_en_i) begin
        wb_dest_q  <= wb_dest_i;
        wb_value_q <= wb_value_i;
      end
    end
  end

  assign wb_en_o    = wb_en_q;
  assign wb_dest_o  = wb_dest_q;
  assign wb_value_o = wb_value_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: passes ALU results through in one cycle, runs loads/stores over a
// req/ack data-memory port, and freezes upstream stages while an access is pending.
//
//   state      | meaning
//   MEM_IDLE   | accept from EXE; ALU ops write back next edge, mem ops are captured
//   MEM_ACCESS | request outstanding from holding registers; wait for mem_ack
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          REG_ADDR_W = 4,
  parameter int          MEM_ADDR_W = 6,
  parameter int unsigned MEM_BASE   = MEM_BASE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exe_valid,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic                  exe_mem_w_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic [DATA_W-1:0]     exe_alu_result,
  input  logic [DATA_W-1:0]     exe_val_rm,
  output logic                  freeze,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0]     wb_value
);

  mem_state_e state_q, state_d;

  logic                  held_we_q;
  logic                  held_wb_en_q;
  logic [REG_ADDR_W-1:0] held_dest_q;
  logic [MEM_ADDR_W-1:0] held_addr_q;
  logic [DATA_W-1:0]     held_wdata_q;

  logic                  mem_op;
  logic                  capture;
  logic [MEM_ADDR_W-1:0] xlat_addr;

  logic                  wb_ld_en;
  logic                  wb_en_d;
  logic [REG_ADDR_W-1:0] wb_dest_d;
  logic [DATA_W-1:0]     wb_value_d;

  assign mem_op = exe_valid & (exe_mem_r_en | exe_mem_w_en);

  // Out-of-window addresses wrap silently; byte offset bits are dropped.
  assign xlat_addr = MEM_ADDR_W'((exe_alu_result - DATA_W'(MEM_BASE)) >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    freeze     = 1'b0;
    wb_ld_en   = 1'b0;
    wb_en_d    = 1'b0;
    wb_dest_d  = exe_dest;
    wb_value_d = exe_alu_result;
    case (state_q)
      MEM_IDLE: begin
        if (mem_op) begin
          capture = 1'b1;
          freeze  = 1'b1;
          state_d = MEM_ACCESS;
        end else begin
          wb_ld_en = 1'b1;
          wb_en_d  = exe_valid & exe_wb_en;
        end
      end
      MEM_ACCESS: begin
        if (mem_ack) begin
          state_d = MEM_IDLE;
          if (!held_we_q) begin
            wb_ld_en   = 1'b1;
            wb_en_d    = held_wb_en_q;
            wb_dest_d  = held_dest_q;
            wb_value_d = mem_rdata;
          end
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // A simultaneous read+write request is treated as a store.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_we_q    <= 1'b0;
      held_wb_en_q <= 1'b0;
      held_dest_q  <= '0;
      held_addr_q  <= '0;
      held_wdata_q <= '0;
    end else if (capture) begin
      held_we_q    <= exe_mem_w_en;
      held_wb_en_q <= exe_wb_en;
      held_dest_q  <= exe_dest;
      held_addr_q  <= xlat_addr;
      held_wdata_q <= exe_val_rm;
    end
  end

  assign mem_req   = (state_q == MEM_ACCESS);
  assign mem_we    = held_we_q;
  assign mem_addr  = held_addr_q;
  assign mem_wdata = held_wdata_q;

  mem_wb_reg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .ld_en_i    (wb_ld_en),
    .wb_en_i    (wb_en_d),
    .wb_dest_i  (wb_dest_d),
    .wb_value_i (wb_value_d),
    .wb_en_o    (wb_en),
    .wb_dest_o  (wb_dest),
    .wb_value_o (wb_value)
  );

endmodule
